frame_buf_reader: RTL and testbench

Scan-out reader for the 320x240 24-bit frame buffer. On a `start` pulse from the display controller it reads every pixel address in ascending order through the frame buffer's synchronous read port and pushes the pixels into the display pixel FIFO. The FIFO's `fifo_full` applies backpressure. This block is the read-side counterpart of the map/sprite writers that fill the frame buffer, and it shares the same address space and pixel format.

---
 rtl/frame_buf_reader_pkg.sv | 18 +
 rtl/frame_buf_reader_if.sv | 36 +++
 rtl/frame_buf_reader_skid.sv | 48 ++++
 rtl/frame_buf_reader.sv | 108 ++++++++++
 tb/tb_frame_buf_reader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/frame_buf_reader_pkg.sv
// Shared display definitions: frame buffer geometry, address/pixel widths and
// the RGB 8:8:8 pixel format used by the frame buffer readers and writers.
package frame_buf_reader_pkg;

    localparam int unsigned FB_WIDTH   = 320;
    localparam int unsigned FB_HEIGHT  = 240;
    localparam int unsigned NUM_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W     = $clog2(NUM_PIXELS);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int unsigned DATA_W = $bits(pixel_t);

endpackage

// File: rtl/frame_buf_reader_if.sv
// Frame buffer read port plus display pixel FIFO write port, as seen by the
// scan-out reader (master) and by the memory/FIFO side (slave).
interface frame_buf_reader_if #(
    parameter int unsigned ADDR_W = frame_buf_reader_pkg::ADDR_W,
    parameter int unsigned DATA_W = frame_buf_reader_pkg::DATA_W
) ();

    logic              frame_buf_re;
    logic [ADDR_W-1:0] frame_buf_addr;
    logic [DATA_W-1:0] frame_buf_rdata;
    logic              fifo_full;
    logic              fifo_we;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_sof;

    modport master (
        output frame_buf_re,
        output frame_buf_addr,
        input  frame_buf_rdata,
        input  fifo_full,
        output fifo_we,
        output fifo_data,
        output fifo_sof
    );

    modport slave (
        input  frame_buf_re,
        input  frame_buf_addr,
        output frame_buf_rdata,
        output fifo_full,
        input  fifo_we,
        input  fifo_data,
        input  fifo_sof
    );

endinterface

// File: rtl/frame_buf_reader_skid.sv
// pixel_skid_buf: one-entry hold register catching read data that returns
// while the pixel FIFO is full, plus the FIFO write strobe/data mux.
module pixel_skid_buf #(
    parameter int unsigned DATA_W = frame_buf_reader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              fifo_full,
    output logic              hold_valid,
    output logic              wr_en_c,
    output logic [DATA_W-1:0] wr_data_c
);

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // Capture on a blocked return; release as soon as the FIFO has room.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        wr_en_c      = (rd_valid || hold_valid_q) && !fifo_full;
        wr_data_c    = '0;
        if (rd_valid && fifo_full) begin
            hold_valid_d = 1'b1;
            hold_data_d  = rd_data;
        end else if (hold_valid_q && !fifo_full) begin
            hold_valid_d = 1'b0;
        end
        if (wr_en_c) begin
            wr_data_c = hold_valid_q ? hold_data_q : rd_data;
        end
    end

    assign hold_valid = hold_valid_q;

endmodule

// File: rtl/frame_buf_reader.sv
// Frame buffer scan-out reader: on start, reads every pixel address in order
// and pushes the pixels into the display FIFO, honouring fifo_full.
module frame_buf_reader #(
    parameter int unsigned NUM_PIXELS = frame_buf_reader_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W     = frame_buf_reader_pkg::ADDR_W,
    parameter int unsigned DATA_W     = frame_buf_reader_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    frame_buf_reader_if.master  bus
);

    import frame_buf_reader_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
    logic              rd_pending_q, rd_pending_d;
    logic              first_q,      first_d;

    logic              issue_c;
    logic              hold_valid;
    logic              wr_en_c;
    logic [DATA_W-1:0] wr_data_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            rd_pending_q <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            rd_pending_q <= rd_pending_d;
            first_q      <= first_d;
        end
    end

    // Next state, read issue and address counter; at most one read in flight.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        rd_pending_d = 1'b0;
        first_d      = first_q;
        issue_c      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    rd_addr_d = '0;
                    first_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!bus.fifo_full && !hold_valid) begin
                    issue_c      = 1'b1;
                    rd_pending_d = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final pixel can still be outstanding here.
                if (wr_en_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_en_c) begin
            first_d = 1'b0;
        end
    end

    pixel_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .rd_valid   (rd_pending_q),
        .rd_data    (bus.frame_buf_rdata),
        .fifo_full  (bus.fifo_full),
        .hold_valid (hold_valid),
        .wr_en_c    (wr_en_c),
        .wr_data_c  (wr_data_c)
    );

    assign done               = (state_q == ST_IDLE);
    assign bus.frame_buf_re   = issue_c;
    assign bus.frame_buf_addr = rd_addr_q;
    assign bus.fifo_we        = wr_en_c;
    assign bus.fifo_data      = wr_data_c;
    assign bus.fifo_sof       = wr_en_c & first_q;

endmodule

// File: tb/tb_frame_buf_reader.sv
// Self-checking bench for frame_buf_reader on a reduced-size frame, using a
// data=address frame buffer model and an in-order pixel scoreboard.
module tb_frame_buf_reader;

    localparam int unsigned N      = 8000;
    localparam int unsigned DATA_W = frame_buf_reader_pkg::DATA_W;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic done;

    int n_checks = 0;
    int n_errors = 0;

    frame_buf_reader_if bus ();

    frame_buf_reader #(
        .NUM_PIXELS (N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Frame buffer model: synchronous read, contents equal to the address.
    always @(posedge clk) begin
        if (bus.frame_buf_re) bus.frame_buf_rdata <= DATA_W'(bus.frame_buf_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_done"}, 32'(done), 1);
        check_eq({tag, "_re"},   32'(bus.frame_buf_re), 0);
        check_eq({tag, "_addr"}, 32'(bus.frame_buf_addr), 0);
        check_eq({tag, "_we"},   32'(bus.fifo_we), 0);
        check_eq({tag, "_sof"},  32'(bus.fifo_sof), 0);
        check_eq({tag, "_data"}, 32'(bus.fifo_data), 0);
    endtask

    // One frame: full_pct random backpressure, optional 10-cycle stall after the
    // issue of address 100, optional ignored restart, optional mid-frame reset.
    task automatic run_frame(input int full_pct, input bit do_stall, input int restart_at,
                             input int reset_at, input int exp_cycles);
        int idx = 0;
        int issues = 0;
        int cyc;
        int stall_left = 0;
        bit stall_armed = do_stall;
        bit release_next = 1'b0;
        bit post_stall = 1'b0;
        bit restarted = 1'b0;
        bit aborted = 1'b0;

        @(posedge clk); #1;
        start = 1'b1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check_eq("done_before_start", 32'(done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (idx < int'(N) && cyc < 4 * int'(N) + 100) begin
            if (reset_at >= 0 && idx == reset_at) begin
                rst = 1'b0;
                bus.fifo_full = 1'b0;
                @(negedge clk);
                check_reset_outputs("midframe_reset");
                @(posedge clk); #1;
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            start = 1'b0;
            if (restart_at >= 0 && idx == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (stall_left > 0) begin
                bus.fifo_full = 1'b1;
                stall_left--;
                if (stall_left == 0) release_next = 1'b1;
            end else if (release_next) begin
                bus.fifo_full = 1'b0;
                release_next = 1'b0;
                post_stall = 1'b1;
            end else begin
                bus.fifo_full = (full_pct > 0) && (int'($urandom_range(99)) < full_pct);
            end

            @(negedge clk);
            if (cyc == 1) begin
                check_eq("done_fall", 32'(done), 0);
                if (exp_cycles > 0) check_eq("first_issue", 32'(bus.frame_buf_re), 1);
            end
            if (bus.fifo_full) begin
                check_eq("re_while_full", 32'(bus.frame_buf_re), 0);
                check_eq("we_while_full", 32'(bus.fifo_we), 0);
            end
            if (post_stall) begin
                check_eq("stall_release_we", 32'(bus.fifo_we), 1);
                check_eq("stall_release_data", 32'(bus.fifo_data), 100);
                post_stall = 1'b0;
            end
            if (bus.frame_buf_re) begin
                check_eq("rd_addr", 32'(bus.frame_buf_addr), 32'(issues));
                if (stall_armed && issues == 100) begin
                    stall_left = 10;
                    stall_armed = 1'b0;
                end
                issues++;
            end
            if (bus.fifo_we) begin
                check_eq("wr_data", 32'(bus.fifo_data), 32'(idx));
                check_eq("wr_sof", 32'(bus.fifo_sof), 32'(idx == 0));
                check_eq("done_busy", 32'(done), 0);
                idx++;
            end else if (bus.fifo_sof) begin
                check_eq("sof_without_we", 32'(bus.fifo_sof), 0);
            end
            check_eq("in_flight", 32'((issues - idx) <= 1), 1);
            @(posedge clk); #1;
            cyc++;
        end

        if (!aborted) begin
            check_eq("frame_writes", 32'(idx), N);
            check_eq("frame_reads", 32'(issues), N);
            start = 1'b0;
            bus.fifo_full = 1'b0;
            @(negedge clk);
            check_eq("done_rise", 32'(done), 1);
            if (exp_cycles > 0) check_eq("frame_cycles", 32'(cyc), 32'(exp_cycles));
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check_eq("idle_we", 32'(bus.fifo_we), 0);
                check_eq("idle_re", 32'(bus.frame_buf_re), 0);
                check_eq("idle_done", 32'(done), 1);
            end
        end
    endtask

    initial begin
        bus.fifo_full = 1'b0;
        bus.frame_buf_rdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        run_frame(0,  1'b0, -1,   -1,   int'(N) + 2);
        run_frame(30, 1'b0, -1,   -1,   0);
        run_frame(0,  1'b1, -1,   -1,   0);
        run_frame(0,  1'b0, 5000, -1,   int'(N) + 2);
        run_frame(0,  1'b0, -1,   4000, 0);
        run_frame(0,  1'b0, -1,   -1,   int'(N) + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
